// File: rtl/sc_dec_pkg.sv
// rtl/sc_dec_pkg.sv - shared types, constants and LLR helpers for the SC decoder datapath
package sc_dec_pkg;

  localparam int LLR_W = 8;
  typedef logic signed [LLR_W-1:0] llr_t;
  localparam llr_t LLR_MAX = llr_t'((1 << (LLR_W - 1)) - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  function automatic int llr_abs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Symmetric saturation to +/-(2^(dw-1)-1) so the most negative code never appears.
  function automatic int llr_sat(input int v, input int dw);
    int m;
    m = (1 << (dw - 1)) - 1;
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

endpackage

// File: rtl/sc_llr_pe.sv
// rtl/sc_llr_pe.sv - single-lane combinational f/g LLR update with input clamp and output saturation
module sc_llr_pe
  import sc_dec_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  fg_sel,
  input  logic                  u,
  output logic [DATA_WIDTH-1:0] r
);

  localparam int MAXV = (1 << (DATA_WIDTH - 1)) - 1;

  int ai;
  int bi;
  int mag;
  int res;

  always_comb begin
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (ai < -MAXV) ai = -MAXV;
    if (bi < -MAXV) bi = -MAXV;
    mag = (llr_abs(ai) < llr_abs(bi)) ? llr_abs(ai) : llr_abs(bi);
    if (!fg_sel) begin
      res = ((ai < 0) != (bi < 0)) ? -mag : mag;
    end else begin
      res = llr_sat(u ? (bi - ai) : (bi + ai), DATA_WIDTH);
    end
    r = DATA_WIDTH'(res);
  end

endmodule

// File: rtl/sc_llr_stage_engine.sv
// rtl/sc_llr_stage_engine.sv - one SC decoder stage over PE_NUM f/g lanes with pipelined LLR memory access
module sc_llr_stage_engine
  import sc_dec_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int N_LOG2      = 10,
  parameter int PE_NUM      = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int STAGE_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [STAGE_WIDTH-1:0]         stage_num,
  input  logic                           fg_sel,
  input  logic [ADDR_WIDTH-1:0]          base_in,
  input  logic [ADDR_WIDTH-1:0]          base_out,
  input  logic                           frozen,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en_a,
  output logic                           rd_en_b,
  output logic [ADDR_WIDTH-1:0]          rd_addr_a,
  output logic [ADDR_WIDTH-1:0]          rd_addr_b,
  input  logic [PE_NUM*DATA_WIDTH-1:0]   rd_data_a,
  input  logic [PE_NUM*DATA_WIDTH-1:0]   rd_data_b,
  input  logic [PE_NUM-1:0]              ps_data,
  output logic [ADDR_WIDTH-1:0]          ps_addr,
  output logic                           wr_en,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic [PE_NUM*DATA_WIDTH-1:0]   wr_data,
  output logic [PE_NUM-1:0]              wr_mask,
  output logic                           bit_valid,
  output logic                           hard_bit
);

  localparam int PE_LOG2 = (PE_NUM > 1) ? $clog2(PE_NUM) : 0;
  localparam int CNT_W   = N_LOG2;
  localparam int WORD_W  = PE_NUM * DATA_WIDTH;

  state_t state_q;
  state_t state_d;

  logic                   fg_q;
  logic                   frozen_q;
  logic                   sub_q;
  logic                   s0_q;
  logic [ADDR_WIDTH-1:0]  base_in_q;
  logic [ADDR_WIDTH-1:0]  base_out_q;
  logic [CNT_W-1:0]       l_q;
  logic [CNT_W-1:0]       nbeats_q;
  logic [CNT_W-1:0]       beat_q;
  logic [CNT_W-1:0]       k1_q;
  logic [PE_NUM-1:0]      lmask_q;
  logic                   v1_q;

  logic [STAGE_WIDTH-1:0] s_eff;
  logic [CNT_W-1:0]       l_calc;
  logic [CNT_W-1:0]       nb_calc;
  logic                   sub_calc;
  logic [PE_NUM-1:0]      mask_calc;
  logic                   issue;
  logic                   last_beat;

  logic [DATA_WIDTH-1:0]  a_lane [PE_NUM];
  logic [DATA_WIDTH-1:0]  b_lane [PE_NUM];
  logic [DATA_WIDTH-1:0]  r_lane [PE_NUM];
  logic [WORD_W-1:0]      wdata_d;

  // Stage geometry is derived from the requested stage, clamped to the largest legal stage.
  always_comb begin
    s_eff = stage_num;
    if (int'(stage_num) > N_LOG2 - 1) s_eff = STAGE_WIDTH'(N_LOG2 - 1);
    l_calc   = CNT_W'(1) << s_eff;
    sub_calc = int'(l_calc) < PE_NUM;
    nb_calc  = sub_calc ? CNT_W'(1) : (l_calc >> PE_LOG2);
    for (int i = 0; i < PE_NUM; i++) begin
      mask_calc[i] = !sub_calc || (i < int'(l_calc));
    end
  end

  assign issue     = (state_q == ISSUE);
  assign last_beat = (beat_q == nbeats_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (last_beat) state_d = DRAIN;
      DRAIN:   if (!v1_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rd_en_a   = issue;
  assign rd_en_b   = issue && !sub_q;
  assign rd_addr_a = issue ? base_in_q + ADDR_WIDTH'(beat_q) : '0;
  assign rd_addr_b = rd_en_b ? base_in_q + ADDR_WIDTH'(beat_q) + ADDR_WIDTH'(nbeats_q) : '0;
  assign ps_addr   = rd_addr_a;

  // In sub-word mode both halves of the node live in one word: b sits L lanes above a.
  always_comb begin
    for (int i = 0; i < PE_NUM; i++) begin
      a_lane[i] = rd_data_a[i*DATA_WIDTH +: DATA_WIDTH];
      b_lane[i] = rd_data_b[i*DATA_WIDTH +: DATA_WIDTH];
      if (sub_q) begin
        b_lane[i] = '0;
        for (int j = 0; j < PE_NUM; j++) begin
          if (j == i + int'(l_q)) b_lane[i] = rd_data_a[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar i = 0; i < PE_NUM; i++) begin : g_pe
    sc_llr_pe #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_pe (
      .a      (a_lane[i]),
      .b      (b_lane[i]),
      .fg_sel (fg_q),
      .u      (ps_data[i]),
      .r      (r_lane[i])
    );
  end

  always_comb begin
    wdata_d = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (lmask_q[i]) wdata_d[i*DATA_WIDTH +: DATA_WIDTH] = r_lane[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      fg_q       <= 1'b0;
      frozen_q   <= 1'b0;
      sub_q      <= 1'b0;
      s0_q       <= 1'b0;
      base_in_q  <= '0;
      base_out_q <= '0;
      l_q        <= '0;
      nbeats_q   <= '0;
      lmask_q    <= '0;
      beat_q     <= '0;
      k1_q       <= '0;
      v1_q       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_mask    <= '0;
      bit_valid  <= 1'b0;
      hard_bit   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        fg_q       <= fg_sel;
        frozen_q   <= frozen;
        sub_q      <= sub_calc;
        s0_q       <= (s_eff == '0);
        base_in_q  <= base_in;
        base_out_q <= base_out;
        l_q        <= l_calc;
        nbeats_q   <= nb_calc;
        lmask_q    <= mask_calc;
      end
      beat_q <= issue ? beat_q + CNT_W'(1) : '0;
      v1_q   <= issue;
      k1_q   <= beat_q;
      // Read data arrives one cycle after issue; the PE result is registered into the write port.
      wr_en     <= v1_q;
      wr_addr   <= v1_q ? base_out_q + ADDR_WIDTH'(k1_q) : '0;
      wr_data   <= v1_q ? wdata_d : '0;
      wr_mask   <= v1_q ? lmask_q : '0;
      bit_valid <= v1_q && s0_q;
      if (v1_q && s0_q) hard_bit <= !frozen_q && r_lane[0][DATA_WIDTH-1];
    end
  end

endmodule
